lc2k_reg_file: RTL and testbench

Parametrised LC2K architectural register file with two combinational read ports and one clocked write port. Adds write-through bypass, an optional hardwired-zero r0, and a hardware initialisation sequencer. The sequencer walks every entry after reset or on request and signals completion with `ready`. It sits between decode (register addresses) and execute (`aluValA`, `regBvalue`) in the CPU datapath.

---
 rtl/lc2k_reg_file.sv | 110 +++++++++++
 tb/tb_lc2k_reg_file.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc2k_reg_file.sv
// LC2K architectural register file: two combinational read ports with write-through
// bypass, one clocked write port, optional hardwired-zero r0 and an init sweep sequencer.
module lc2k_reg_file #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 3,
    parameter bit ZERO_R0       = 1'b1,
    parameter bit INIT_IDENTITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_regA,
    input  logic [ADDR_W-1:0] read_regB,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_value,
    input  logic              write_en,
    input  logic              clear_req,
    output logic [DATA_W-1:0] aluValA,
    output logic [DATA_W-1:0] regBvalue,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   next_idx;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    // The sweep and the user write share the single array write port.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        mem_we     = 1'b0;
        mem_addr   = write_reg;
        mem_data   = write_value;
        case (state)
            ST_INIT: begin
                mem_we   = 1'b1;
                mem_addr = idx[ADDR_W-1:0];
                mem_data = INIT_IDENTITY ? DATA_W'(idx) : '0;
                if (idx == LAST_IDX) begin
                    next_state = ST_READY;
                end else begin
                    next_idx = idx + 1'b1;
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    next_state = ST_INIT;
                    next_idx   = '0;
                end else begin
                    mem_we = write_en && !(ZERO_R0 && (write_reg == '0));
                end
            end
            default: begin
                next_state = ST_INIT;
                next_idx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            regs[mem_addr] <= mem_data;
        end
    end

    // Hardwired zero outranks bypass; bypass outranks stored contents.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (state != ST_READY) begin
            val = '0;
        end else if (ZERO_R0 && (addr == '0)) begin
            val = '0;
        end else if (write_en && (write_reg == addr)) begin
            val = write_value;
        end else begin
            val = regs[addr];
        end
        return val;
    endfunction

    always_comb begin
        aluValA   = read_port(read_regA);
        regBvalue = read_port(read_regB);
        ready     = (state == ST_READY);
    end

endmodule

// File: tb/tb_lc2k_reg_file.sv
// Bench for lc2k_reg_file: a default instance (8x32, zero r0) and a wide one
// (32x16, identity init, writable r0) checked against a behavioural model.
module tb_lc2k_reg_file;

    logic        clk;
    logic        rst_n;
    logic        chk_en;
    int          total;
    int          bad;

    logic [2:0]  ra_a, rb_a, wr_a;
    logic [31:0] wv_a;
    logic        we_a, clr_a;
    logic [31:0] alu_a, regb_a;
    logic        ready_a;

    logic [4:0]  ra_b, rb_b, wr_b;
    logic [15:0] wv_b;
    logic        we_b, clr_b;
    logic [15:0] alu_b, regb_b;
    logic        ready_b;

    lc2k_reg_file #(
        .DATA_W(32), .ADDR_W(3), .ZERO_R0(1'b1), .INIT_IDENTITY(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .read_regA(ra_a), .read_regB(rb_a), .write_reg(wr_a),
        .write_value(wv_a), .write_en(we_a), .clear_req(clr_a),
        .aluValA(alu_a), .regBvalue(regb_a), .ready(ready_a)
    );

    lc2k_reg_file #(
        .DATA_W(16), .ADDR_W(5), .ZERO_R0(1'b0), .INIT_IDENTITY(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .read_regA(ra_b), .read_regB(rb_b), .write_reg(wr_b),
        .write_value(wv_b), .write_en(we_b), .clear_req(clr_b),
        .aluValA(alu_b), .regBvalue(regb_b), .ready(ready_b)
    );

    always #5 clk = ~clk;

    // Model: a file is either sweeping (counting entries written so far) or ready.
    logic [31:0] mem_a [8];
    int          swept_a;
    bit          rdy_a;
    logic [15:0] mem_b [32];
    int          swept_b;
    bit          rdy_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swept_a <= 0;
            rdy_a   <= 1'b0;
        end else if (!rdy_a) begin
            mem_a[swept_a] <= 32'd0;
            swept_a        <= swept_a + 1;
            rdy_a          <= (swept_a + 1 == 8);
        end else if (clr_a) begin
            swept_a <= 0;
            rdy_a   <= 1'b0;
        end else if (we_a && wr_a != 3'd0) begin
            mem_a[wr_a] <= wv_a;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swept_b <= 0;
            rdy_b   <= 1'b0;
        end else if (!rdy_b) begin
            mem_b[swept_b] <= 16'(swept_b);
            swept_b        <= swept_b + 1;
            rdy_b          <= (swept_b + 1 == 32);
        end else if (clr_b) begin
            swept_b <= 0;
            rdy_b   <= 1'b0;
        end else if (we_b) begin
            mem_b[wr_b] <= wv_b;
        end
    end

    function automatic logic [31:0] exp_a(input logic [2:0] addr);
        if (!rdy_a || addr == 3'd0) return 32'd0;
        if (we_a && wr_a == addr) return wv_a;
        return mem_a[addr];
    endfunction

    function automatic logic [31:0] exp_b(input logic [4:0] addr);
        if (!rdy_b) return 32'd0;
        if (we_b && wr_b == addr) return 32'(wv_b);
        return 32'(mem_b[addr]);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model_ready_a", 32'(ready_a), 32'(rdy_a));
            checkOutput("model_alu_a", alu_a, exp_a(ra_a));
            checkOutput("model_regb_a", regb_a, exp_a(rb_a));
            checkOutput("model_ready_b", 32'(ready_b), 32'(rdy_b));
            checkOutput("model_alu_b", 32'(alu_b), exp_b(ra_b));
            checkOutput("model_regb_b", 32'(regb_b), exp_b(rb_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] wr,
                                 input logic [31:0] wv, input logic we, input logic clr);
        ra_a = ra; rb_a = rb; wr_a = wr; wv_a = wv; we_a = we; clr_a = clr;
    endtask

    task automatic applyStimulusB(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] wr,
                                  input logic [15:0] wv, input logic we, input logic clr);
        ra_b = ra; rb_b = rb; wr_b = wr; wv_b = wv; we_b = we; clr_b = clr;
    endtask

    // Counts clock edges until each file reports ready; 0 means it never did.
    task automatic wait_both(output int na, output int nb);
        na = 0;
        nb = 0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (ready_a && na == 0) na = c;
            if (ready_b && nb == 0) nb = c;
            if (na != 0 && nb != 0) break;
        end
    endtask

    int na, nb, nlow;

    initial begin
        clk = 1'b0; rst_n = 1'b1; chk_en = 1'b0; total = 0; bad = 0;
        applyStimulus(3'd0, 3'd0, 3'd0, 32'd0, 1'b0, 1'b0);
        applyStimulusB(5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        checkOutput("rst_ready_a", 32'(ready_a), 32'd0);
        checkOutput("rst_alu_a", alu_a, 32'd0);
        checkOutput("rst_regb_a", regb_a, 32'd0);
        checkOutput("rst_ready_b", 32'(ready_b), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        wait_both(na, nb);
        checkOutput("init_len_a", 32'(na), 32'd8);
        checkOutput("init_len_b", 32'(nb), 32'd32);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), 3'(7 - i), 3'd0, 32'd0, 1'b0, 1'b0);
            #1;
            checkOutput("init_zero_a", alu_a, 32'd0);
            checkOutput("init_zero_b", regb_a, 32'd0);
        end
        for (int i = 0; i < 32; i++) begin
            applyStimulusB(5'(i), 5'(31 - i), 5'd0, 16'd0, 1'b0, 1'b0);
            #1;
            checkOutput("init_ident_a", 32'(alu_b), 32'(i));
            checkOutput("init_ident_b", 32'(regb_b), 32'(31 - i));
        end
        applyStimulusB(5'd31, 5'd31, 5'd0, 16'd0, 1'b0, 1'b0);
        #1 checkOutput("init_r31", 32'(alu_b), 32'h0000_001F);
        tick();

        applyStimulus(3'd0, 3'd0, 3'd3, 32'hDEAD_BEEF, 1'b1, 1'b0);
        tick();
        applyStimulus(3'd3, 3'd3, 3'd0, 32'd0, 1'b0, 1'b0);
        #1;
        checkOutput("wr_r3_a", alu_a, 32'hDEAD_BEEF);
        checkOutput("wr_r3_b", regb_a, 32'hDEAD_BEEF);
        tick();
        applyStimulus(3'd5, 3'd5, 3'd5, 32'h0000_1234, 1'b1, 1'b0);
        #1;
        checkOutput("bypass_a", alu_a, 32'h0000_1234);
        checkOutput("bypass_b", regb_a, 32'h0000_1234);
        tick();
        applyStimulus(3'd5, 3'd0, 3'd0, 32'd0, 1'b0, 1'b0);
        #1 checkOutput("bypass_stored", alu_a, 32'h0000_1234);
        tick();

        applyStimulus(3'd0, 3'd0, 3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        #1 checkOutput("r0_bypass_blocked", alu_a, 32'd0);
        tick();
        applyStimulus(3'd0, 3'd0, 3'd0, 32'd0, 1'b0, 1'b0);
        #1 checkOutput("r0_store_blocked", alu_a, 32'd0);
        applyStimulusB(5'd0, 5'd0, 5'd0, 16'hFFFF, 1'b1, 1'b0);
        #1 checkOutput("r0_bypass_b", 32'(alu_b), 32'h0000_FFFF);
        tick();
        applyStimulusB(5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0);
        #1 checkOutput("r0_store_b", 32'(alu_b), 32'h0000_FFFF);
        tick();

        for (int i = 1; i < 8; i++) begin
            applyStimulus(3'd0, 3'd0, 3'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 1'b1, 1'b0);
            tick();
        end
        for (int i = 1; i < 8; i++) begin
            applyStimulus(3'(i), 3'(i), 3'd0, 32'd0, 1'b0, 1'b0);
            #1;
            checkOutput("fill_rd", regb_a, 32'h1000_0000 + 32'(i) * 32'h0101_0101);
        end
        applyStimulus(3'd2, 3'd2, 3'd2, 32'h0000_00AA, 1'b1, 1'b1);
        tick();
        checkOutput("clear_ready_low", 32'(ready_a), 32'd0);
        nlow = 0;
        for (int c = 1; c <= 100; c++) begin
            applyStimulus(3'd2, 3'd2, 3'd2, 32'h0000_00AA, 1'b1, c[0]);
            tick();
            if (ready_a) begin
                nlow = c;
                break;
            end
        end
        applyStimulus(3'd0, 3'd0, 3'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("clear_len", 32'(nlow), 32'd8);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), 3'(i), 3'd0, 32'd0, 1'b0, 1'b0);
            #1 checkOutput("clear_zero", alu_a, 32'd0);
        end
        tick();

        applyStimulus(3'd0, 3'd0, 3'd0, 32'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(3'd1, 3'd1, 3'd0, 32'd0, 1'b0, 1'b0);
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midinit_rst_ready", 32'(ready_a), 32'd0);
        checkOutput("midinit_rst_alu_b", 32'(alu_b), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_both(na, nb);
        checkOutput("midinit_len_a", 32'(na), 32'd8);
        checkOutput("midinit_len_b", 32'(nb), 32'd32);

        applyStimulus(3'd6, 3'd6, 3'd6, 32'h0000_0055, 1'b1, 1'b0);
        tick();
        applyStimulus(3'd6, 3'd6, 3'd6, 32'h0000_0077, 1'b1, 1'b0);
        #1 checkOutput("prerst_bypass", alu_a, 32'h0000_0077);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("wr_rst_alu", alu_a, 32'd0);
        checkOutput("wr_rst_regb", regb_a, 32'd0);
        checkOutput("wr_rst_ready", 32'(ready_a), 32'd0);
        tick();
        applyStimulus(3'd6, 3'd6, 3'd0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        wait_both(na, nb);
        checkOutput("wr_rst_len_a", 32'(na), 32'd8);
        checkOutput("wr_rst_len_b", 32'(nb), 32'd32);
        #1 checkOutput("wr_rst_r6", alu_a, 32'd0);

        for (int i = 0; i < 32; i++) begin
            applyStimulusB(5'd0, 5'd0, 5'(i), 16'hB000 + 16'(i) * 16'h0021, 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            applyStimulusB(5'(i), 5'(31 - i), 5'd0, 16'd0, 1'b0, 1'b0);
            #1;
            checkOutput("b2b_rd_a", 32'(alu_b), 32'(16'hB000 + 16'(i) * 16'h0021));
            checkOutput("b2b_rd_b", 32'(regb_b), 32'(16'hB000 + 16'(31 - i) * 16'h0021));
        end
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
